// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_pkg
// Description : Standard VGA/DVI mode timing sets (per-axis pixel, porch,
//               sync and polarity values).
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_gen_pkg;

    typedef struct packed {
        int   pix;
        int   fp;
        int   sync;
        int   bp;
        logic pol;
    } vga_axis_t;

    // Each mode is an (H, V) pair; pol = 1 means active-high sync.
    localparam vga_axis_t c_VGA_640X480_H  = '{pix: 640,  fp: 16,  sync: 96,  bp: 48,  pol: 1'b0};
    localparam vga_axis_t c_VGA_640X480_V  = '{pix: 480,  fp: 10,  sync: 2,   bp: 33,  pol: 1'b0};
    localparam vga_axis_t c_VGA_800X600_H  = '{pix: 800,  fp: 40,  sync: 128, bp: 88,  pol: 1'b1};
    localparam vga_axis_t c_VGA_800X600_V  = '{pix: 600,  fp: 1,   sync: 4,   bp: 23,  pol: 1'b1};
    localparam vga_axis_t c_VGA_1280X720_H = '{pix: 1280, fp: 110, sync: 40,  bp: 220, pol: 1'b1};
    localparam vga_axis_t c_VGA_1280X720_V = '{pix: 720,  fp: 5,   sync: 5,   bp: 20,  pol: 1'b1};

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_axis_ctr.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_ctr
// Description : One raster axis: wrapping position counter plus next-state
//               sync/active decode and an end-of-axis wrap flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_ctr
    import vga_timing_gen_pkg::*;
#(
    parameter int   PIX   = 640,
    parameter int   FP    = 16,
    parameter int   SYNC  = 96,
    parameter int   BP    = 48,
    parameter logic POL   = 1'b0,
    localparam int  TOTAL = PIX + FP + SYNC + BP,
    localparam int  W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    output logic [W-1:0] pos,
    output logic         sync_nxt,
    output logic         active_nxt,
    output logic         wrap
);

    localparam logic [W-1:0] c_LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] c_PIX      = W'(PIX);
    localparam logic [W-1:0] c_SYNC_BEG = W'(PIX + FP);
    localparam logic [W-1:0] c_SYNC_END = W'(PIX + FP + SYNC);

    if (PIX < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_param_check
        $error("vga_axis_ctr: every timing parameter must be at least 1");
    end

    logic [W-1:0] r_pos;
    logic [W-1:0] w_pos_nxt;
    logic         w_in_sync;

    assign wrap = (r_pos == c_LAST);

    always_comb begin
        w_pos_nxt = r_pos;
        if (adv) begin
            w_pos_nxt = wrap ? '0 : r_pos + 1'b1;
        end
    end

    // Reset parks on the last position so the first advance lands on 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos <= c_LAST;
        end else begin
            r_pos <= w_pos_nxt;
        end
    end

    assign w_in_sync  = (w_pos_nxt >= c_SYNC_BEG) && (w_pos_nxt < c_SYNC_END);
    assign sync_nxt   = w_in_sync ? POL : ~POL;
    assign active_nxt = (w_pos_nxt < c_PIX);
    assign pos        = r_pos;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised raster timing generator with registered sync,
//               data-enable, coordinates and line/frame strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   H_PIX        = c_VGA_640X480_H.pix,
    parameter int   H_FP         = c_VGA_640X480_H.fp,
    parameter int   H_SYNC_PULSE = c_VGA_640X480_H.sync,
    parameter int   H_BP         = c_VGA_640X480_H.bp,
    parameter int   V_PIX        = c_VGA_640X480_V.pix,
    parameter int   V_FP         = c_VGA_640X480_V.fp,
    parameter int   V_SYNC_PULSE = c_VGA_640X480_V.sync,
    parameter int   V_BP         = c_VGA_640X480_V.bp,
    parameter logic H_POL        = c_VGA_640X480_H.pol,
    parameter logic V_POL        = c_VGA_640X480_V.pol,
    localparam int  H_TOTAL      = H_PIX + H_FP + H_SYNC_PULSE + H_BP,
    localparam int  V_TOTAL      = V_PIX + V_FP + V_SYNC_PULSE + V_BP,
    localparam int  HW           = $clog2(H_TOTAL),
    localparam int  VW           = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    logic w_h_sync_nxt, w_h_act_nxt, w_h_wrap;
    logic w_v_sync_nxt, w_v_act_nxt, w_v_wrap;
    logic w_v_adv;

    logic r_hs, r_vs, r_de, r_line_start, r_frame_start;

    assign w_v_adv = w_h_wrap & ce;

    vga_axis_ctr #(
        .PIX  (H_PIX),
        .FP   (H_FP),
        .SYNC (H_SYNC_PULSE),
        .BP   (H_BP),
        .POL  (H_POL)
    ) u_h_ctr (
        .clk        (clk),
        .rst        (rst),
        .adv        (ce),
        .pos        (x),
        .sync_nxt   (w_h_sync_nxt),
        .active_nxt (w_h_act_nxt),
        .wrap       (w_h_wrap)
    );

    vga_axis_ctr #(
        .PIX  (V_PIX),
        .FP   (V_FP),
        .SYNC (V_SYNC_PULSE),
        .BP   (V_BP),
        .POL  (V_POL)
    ) u_v_ctr (
        .clk        (clk),
        .rst        (rst),
        .adv        (w_v_adv),
        .pos        (y),
        .sync_nxt   (w_v_sync_nxt),
        .active_nxt (w_v_act_nxt),
        .wrap       (w_v_wrap)
    );

    // Decode is taken from next-state counters so it lines up with x/y.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs          <= ~H_POL;
            r_vs          <= ~V_POL;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (ce) begin
            r_hs          <= w_h_sync_nxt;
            r_vs          <= w_v_sync_nxt;
            r_de          <= w_h_act_nxt & w_v_act_nxt;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap & w_v_wrap;
        end
    end

    assign hs          = r_hs;
    assign vs          = r_vs;
    assign de          = r_de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench: three generator instances against a
//               frame-index reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct {
        int   hp, hf, hsw, hb, vp, vf, vsw, vb;
        logic hpol, vpol;
    } mode_t;

    typedef struct {
        logic        hs, vs, de, ls, fs, adv, rst;
        logic [31:0] x, y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [2:0] s_x, s_y;
    logic       p_hs, p_vs, p_de, p_ls, p_fs;
    logic [2:0] p_x, p_y;

    vga_timing_gen dut_def (
        .clk(clk), .rst(rst), .ce(ce), .hs(d_hs), .vs(d_vs), .de(d_de),
        .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .H_PIX(4), .H_FP(1), .H_SYNC_PULSE(2), .H_BP(1),
        .V_PIX(3), .V_FP(1), .V_SYNC_PULSE(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut_sm (
        .clk(clk), .rst(rst), .ce(ce), .hs(s_hs), .vs(s_vs), .de(s_de),
        .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
    );

    vga_timing_gen #(
        .H_PIX(4), .H_FP(1), .H_SYNC_PULSE(2), .H_BP(1),
        .V_PIX(3), .V_FP(1), .V_SYNC_PULSE(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut_smp (
        .clk(clk), .rst(rst), .ce(ce), .hs(p_hs), .vs(p_vs), .de(p_de),
        .x(p_x), .y(p_y), .line_start(p_ls), .frame_start(p_fs)
    );

    mode_t m_def, m_sm, m_smp;
    int    pos_def = 0, pos_sm = 0, pos_smp = 0;
    exp_t  q_def[$], q_sm[$], q_smp[$];

    function automatic int frame_len(input mode_t m);
        return (m.hp + m.hf + m.hsw + m.hb) * (m.vp + m.vf + m.vsw + m.vb);
    endfunction

    // The model tracks a single pixel index within the frame.
    function automatic int next_pos(input mode_t m, input int p, input logic r, input logic c);
        if (r) return frame_len(m) - 1;
        if (c) return (p + 1) % frame_len(m);
        return p;
    endfunction

    function automatic exp_t model(input mode_t m, input int p, input logic a, input logic r);
        exp_t e;
        int   ht, xx, yy;
        ht    = m.hp + m.hf + m.hsw + m.hb;
        xx    = p % ht;
        yy    = p / ht;
        e.x   = 32'(xx);
        e.y   = 32'(yy);
        e.hs  = (xx >= m.hp + m.hf && xx < m.hp + m.hf + m.hsw) ? m.hpol : ~m.hpol;
        e.vs  = (yy >= m.vp + m.vf && yy < m.vp + m.vf + m.vsw) ? m.vpol : ~m.vpol;
        e.de  = (xx < m.hp) && (yy < m.vp);
        e.ls  = (xx == 0);
        e.fs  = (xx == 0) && (yy == 0);
        e.adv = a;
        e.rst = r;
        return e;
    endfunction

    task automatic step(input logic r, input logic c);
        rst = r;
        ce  = c;
        @(posedge clk);
        pos_def = next_pos(m_def, pos_def, r, c);
        pos_sm  = next_pos(m_sm,  pos_sm,  r, c);
        pos_smp = next_pos(m_smp, pos_smp, r, c);
        q_def.push_back(model(m_def, pos_def, c && !r, r));
        q_sm.push_back (model(m_sm,  pos_sm,  c && !r, r));
        q_smp.push_back(model(m_smp, pos_smp, c && !r, r));
        #1;
    endtask

    task automatic check(input string name, input exp_t e,
                         input logic hs, input logic vs, input logic de,
                         input logic ls, input logic fs,
                         input logic [31:0] xa, input logic [31:0] ya);
        n_total++;
        if ({hs, vs, de, ls, fs} !== {e.hs, e.vs, e.de, e.ls, e.fs} || xa !== e.x || ya !== e.y) begin
            n_bad++;
            $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                     name, $time, xa, ya, hs, vs, de, ls, fs,
                     e.x, e.y, e.hs, e.vs, e.de, e.ls, e.fs);
        end
    endtask

    task automatic check_count(input string name, input int got, input int want);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d want %0d", name, $time, got, want);
        end
    endtask

    // Per-line / per-frame aggregate counters, counted over advancing cycles only.
    exp_t e_def, e_sm, e_smp;
    bit   line_valid = 0, frame_valid = 0;
    int   hs_lo_cnt = 0, line_len = 0, de_cnt = 0, frame_cnt = 0;

    always @(negedge clk) begin
        if (q_def.size() > 0) begin
            e_def = q_def.pop_front();
            check("default", e_def, d_hs, d_vs, d_de, d_ls, d_fs, 32'(d_x), 32'(d_y));
            if (e_def.rst) begin
                line_valid = 0;
            end else if (e_def.adv) begin
                if (d_ls === 1'b1) begin
                    if (line_valid) begin
                        check_count("hs_low_per_line", hs_lo_cnt, 96);
                        check_count("line_period", line_len, 800);
                    end
                    line_valid = 1;
                    hs_lo_cnt  = 0;
                    line_len   = 0;
                end
                line_len++;
                if (d_hs === 1'b0) hs_lo_cnt++;
            end
        end
        if (q_sm.size() > 0) begin
            e_sm = q_sm.pop_front();
            check("small", e_sm, s_hs, s_vs, s_de, s_ls, s_fs, 32'(s_x), 32'(s_y));
            if (e_sm.rst) begin
                frame_valid = 0;
            end else if (e_sm.adv) begin
                if (s_fs === 1'b1) begin
                    if (frame_valid) begin
                        check_count("de_per_frame", de_cnt, 12);
                        check_count("frame_period", frame_cnt, 48);
                    end
                    frame_valid = 1;
                    de_cnt      = 0;
                    frame_cnt   = 0;
                end
                frame_cnt++;
                if (s_de === 1'b1) de_cnt++;
            end
        end
        if (q_smp.size() > 0) begin
            e_smp = q_smp.pop_front();
            check("small_pos_pol", e_smp, p_hs, p_vs, p_de, p_ls, p_fs, 32'(p_x), 32'(p_y));
        end
    end

    initial begin
        m_def = '{hp: 640, hf: 16, hsw: 96, hb: 48, vp: 480, vf: 10, vsw: 2, vb: 33, hpol: 1'b0, vpol: 1'b0};
        m_sm  = '{hp: 4, hf: 1, hsw: 2, hb: 1, vp: 3, vf: 1, vsw: 1, vb: 1, hpol: 1'b0, vpol: 1'b0};
        m_smp = '{hp: 4, hf: 1, hsw: 2, hb: 1, vp: 3, vf: 1, vsw: 1, vb: 1, hpol: 1'b1, vpol: 1'b1};

        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 1700; i++) step(1'b0, 1'b1);

        for (int i = 0; i < 400; i++) step(1'b0, ($urandom_range(0, 1) == 1));

        // Mid-frame abort at small-mode position x=5, y=2.
        for (int i = 0; i < 100 && pos_sm != 21; i++) step(1'b0, 1'b1);
        if (pos_sm != 21) begin
            n_total++;
            n_bad++;
            $display("FAIL reach_abort_point: got pos=%0d want 21", pos_sm);
        end
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);

        // Reset while ce is low must still load reset values.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b0, ($urandom_range(0, 3) != 0));

        @(negedge clk);
        #1;
        if (q_def.size() != 0 || q_sm.size() != 0 || q_smp.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0",
                     q_def.size() + q_sm.size() + q_smp.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
